pixel_distance_accum: RTL and testbench



---
 rtl/pixel_distance_accum.sv | 139 +++++++++++++
 tb/tb_pixel_distance_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_distance_accum.sv
// Streaming per-frame distance engine: per-lane |a-b| terms, registered lane sum, frame accumulator.
// Optional macro DIST_MANHATTAN_EN selects L1 terms instead of the default squared L2 terms.
module pixel_distance_accum #(
  parameter int unsigned NPIX  = 784,
  parameter int unsigned LANES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [LANES*8-1:0]   in_image,
  input  logic [LANES*8-1:0]   in_test,
  output logic                 out_valid,
  output logic [31:0]          distance
);

  localparam int unsigned BEATS = NPIX / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SUM_W = 16 + $clog2(LANES);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BEATS - 1);

  // Beat counter
  logic [CNT_W-1:0] r_beat_cnt;
  logic             w_first;
  logic             w_last;

  assign w_first = (r_beat_cnt == '0);
  assign w_last  = (r_beat_cnt == LastCnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (in_valid) begin
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + CNT_W'(1);
    end
  end

  // Per-lane terms; the 9-bit difference keeps the sign so |a-b| never wraps
  logic [8:0]  w_diff [LANES];
  logic [7:0]  w_absd [LANES];
  logic [15:0] w_term [LANES];

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      w_diff[i] = {1'b0, in_image[8*i +: 8]} - {1'b0, in_test[8*i +: 8]};
      w_absd[i] = w_diff[i][8] ? 8'(~w_diff[i] + 9'd1) : w_diff[i][7:0];
`ifdef DIST_MANHATTAN_EN
      w_term[i] = {8'd0, w_absd[i]};
`else
      w_term[i] = 16'(w_absd[i]) * 16'(w_absd[i]);
`endif
    end
  end

  // Stage 1: lane terms
  logic [15:0] r_s1_terms [LANES];
  logic        r_s1_valid;
  logic        r_s1_last;
  logic        r_s1_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        r_s1_terms[i] <= '0;
      end
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_last  <= w_last;
        r_s1_first <= w_first;
        for (int unsigned i = 0; i < LANES; i++) begin
          r_s1_terms[i] <= w_term[i];
        end
      end
    end
  end

  // Stage 2: lane sum
  logic [SUM_W-1:0] w_lane_sum;
  logic [SUM_W-1:0] r_s2_sum;
  logic             r_s2_valid;
  logic             r_s2_last;
  logic             r_s2_first;

  always_comb begin
    w_lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_lane_sum = w_lane_sum + SUM_W'(r_s1_terms[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_sum   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_first <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum   <= w_lane_sum;
        r_s2_last  <= r_s1_last;
        r_s2_first <= r_s1_first;
      end
    end
  end

  // Stage 3: frame accumulator; the first beat loads so a new frame can follow with no gap
  logic [31:0] r_acc;
  logic        r_s3_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_s3_last <= 1'b0;
    end else begin
      r_s3_last <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        r_acc <= r_s2_first ? 32'(r_s2_sum) : r_acc + 32'(r_s2_sum);
      end
    end
  end

  // Output capture reads the old accumulator even if the next frame reloads it this edge
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      distance  <= '0;
    end else begin
      out_valid <= r_s3_last;
      if (r_s3_last) begin
        distance <= r_acc;
      end
    end
  end

endmodule

// File: tb/tb_pixel_distance_accum.sv
// Directed bench for pixel_distance_accum; expected distances are hand-computed or from a small model.
// Honours DIST_MANHATTAN_EN so the same bench covers both builds.
module tb_pixel_distance_accum;

  localparam int unsigned NPIX  = 784;
  localparam int unsigned LANES = 16;
  localparam int unsigned BEATS = NPIX / LANES;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic [LANES*8-1:0] in_image;
  logic [LANES*8-1:0] in_test;
  logic               out_valid;
  logic [31:0]        distance;

  pixel_distance_accum #(
    .NPIX  (NPIX),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_image  (in_image),
    .in_test   (in_test),
    .out_valid (out_valid),
    .distance  (distance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_bad = 0;
  int          last_edge = 0;
  int          pulse_edge [$];
  logic [31:0] pulse_dist [$];
  logic [7:0]  img_px [NPIX];
  logic [7:0]  tst_px [NPIX];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      pulse_edge.push_back(cyc);
      pulse_dist.push_back(distance);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic [LANES*8-1:0] img, input logic [LANES*8-1:0] tst);
    @(negedge clk);
    in_valid  = 1'b1;
    in_image  = img;
    in_test   = tst;
    last_edge = cyc + 1;
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < NPIX; i++) begin
      img_px[i] = a;
      tst_px[i] = b;
    end
  endtask

  task automatic fill_random(input bit same);
    for (int i = 0; i < NPIX; i++) begin
      img_px[i] = 8'($urandom_range(255));
      tst_px[i] = same ? img_px[i] : 8'($urandom_range(255));
    end
  endtask

  function automatic logic [31:0] model_dist();
    int acc = 0;
    int d;
    for (int i = 0; i < NPIX; i++) begin
      d = int'(img_px[i]) - int'(tst_px[i]);
      if (d < 0) d = -d;
`ifdef DIST_MANHATTAN_EN
      acc += d;
`else
      acc += d * d;
`endif
    end
    return 32'(acc);
  endfunction

  task automatic send_beats(input int first_beat, input int n_beats, input int gap_pct);
    logic [LANES*8-1:0] iv;
    logic [LANES*8-1:0] tv;
    for (int b = first_beat; b < first_beat + n_beats; b++) begin
      while (int'($urandom_range(99)) < gap_pct) idle(1);
      for (int l = 0; l < LANES; l++) begin
        iv[8*l +: 8] = img_px[b*LANES + l];
        tv[8*l +: 8] = tst_px[b*LANES + l];
      end
      drive_beat(iv, tv);
    end
  endtask

  task automatic finish_frame(input string tag, input logic [31:0] exp);
    idle(6);
    check_eq({tag, "_pulses"}, 32'(pulse_edge.size()), 32'd1);
    if (pulse_edge.size() > 0) begin
      check_eq({tag, "_dist"}, pulse_dist[0], exp);
      check_eq({tag, "_latency"}, 32'(pulse_edge[0] - last_edge), 32'd3);
    end
    check_eq({tag, "_hold"}, distance, exp);
    pulse_edge.delete();
    pulse_dist.delete();
  endtask

  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [31:0] exp_ff;
  logic [31:0] exp_model;

  initial begin
`ifdef DIST_MANHATTAN_EN
    exp_a  = 32'd107408;
    exp_ff = 32'd199920;
`else
    exp_a  = 32'd14714896;
    exp_ff = 32'd50979600;
`endif
    exp_b = 32'd0;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_image = '0;
    in_test  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_distance", distance, 32'd0);
    pulse_edge.delete();
    pulse_dist.delete();

    fill_const(8'h00, 8'h89);
    send_beats(0, BEATS, 0);
    finish_frame("zero_vs_89", exp_a);

    fill_const(8'hFF, 8'h00);
    send_beats(0, BEATS, 0);
    finish_frame("ff_vs_00", exp_ff);

    fill_const(8'h00, 8'hFF);
    send_beats(0, BEATS, 0);
    finish_frame("00_vs_ff", exp_ff);

    fill_random(1'b1);
    send_beats(0, BEATS, 0);
    finish_frame("rand_same", 32'd0);

    fill_random(1'b0);
    exp_model = model_dist();
    send_beats(0, BEATS, 0);
    finish_frame("rand_diff", exp_model);

    send_beats(0, BEATS, 30);
    finish_frame("rand_gaps", exp_model);

    // Back-to-back frames with no idle cycles between them
    fill_const(8'h00, 8'h89);
    send_beats(0, BEATS, 0);
    fill_const(8'h10, 8'h10);
    send_beats(0, BEATS, 0);
    idle(6);
    check_eq("b2b_pulses", 32'(pulse_edge.size()), 32'd2);
    if (pulse_edge.size() == 2) begin
      check_eq("b2b_dist0", pulse_dist[0], exp_a);
      check_eq("b2b_dist1", pulse_dist[1], exp_b);
      check_eq("b2b_spacing", 32'(pulse_edge[1] - pulse_edge[0]), 32'(BEATS));
      check_eq("b2b_latency", 32'(pulse_edge[1] - last_edge), 32'd3);
    end
    pulse_edge.delete();
    pulse_dist.delete();

    // Load a nonzero distance, then abort a frame with reset after 20 beats
    fill_const(8'hFF, 8'h00);
    send_beats(0, BEATS, 0);
    finish_frame("pre_abort", exp_ff);
    fill_const(8'h00, 8'h89);
    send_beats(0, 20, 0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    check_eq("abort_pulses", 32'(pulse_edge.size()), 32'd0);
    check_eq("abort_distance", distance, 32'd0);
    pulse_edge.delete();
    pulse_dist.delete();
    send_beats(0, BEATS, 0);
    finish_frame("after_abort", exp_a);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
